// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// cpu_seq_pkg
// Shared types and constants for the fetch/execute sequencer.
// Revision: 1.0
// ============================================================================
package cpu_seq_pkg;

    localparam int c_default_addr_w = 16;

    // Even byte address carries instruction[15:8].
    localparam bit c_big_endian = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_HI   = 3'd1,
        ST_FETCH_LO   = 3'd2,
        ST_LOAD_IR    = 3'd3,
        ST_EXEC_START = 3'd4,
        ST_EXEC_WAIT  = 3'd5,
        ST_HALT       = 3'd6
    } fseq_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer
// Owns the PC, fetches 16-bit instructions as two byte reads, loads the IR
// and hands off to the execute stage; supports branch loads and halt.
// Revision: 1.0
// ============================================================================
module fetch_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int                ADDR_W   = c_default_addr_w,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ack_in,
    input  logic [7:0]        mem_rdata_in,
    output logic              ir_write_en_out,
    output logic [15:0]       ir_data_out,
    output logic              exec_start_out,
    input  logic              exec_done_in,
    input  logic              pc_load_in,
    input  logic [ADDR_W-1:0] pc_load_addr_in,
    input  logic              halt_in,
    output logic              halted_out,
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [ADDR_W-1:0] c_even_mask = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] c_reset_pc  = RESET_PC & c_even_mask;

    fseq_state_t       r_state;
    fseq_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_hi;
    logic [15:0]       r_ir;
    logic              w_ack;
    logic              w_finish;

    assign w_ack    = mem_req_out & mem_ack_in;
    assign w_finish = ((r_state == ST_EXEC_START) || (r_state == ST_EXEC_WAIT)) & exec_done_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       w_state_nxt = ST_FETCH_HI;
            ST_FETCH_HI:   if (w_ack) w_state_nxt = ST_FETCH_LO;
            ST_FETCH_LO:   if (w_ack) w_state_nxt = ST_LOAD_IR;
            ST_LOAD_IR:    w_state_nxt = ST_EXEC_START;
            ST_EXEC_START,
            ST_EXEC_WAIT: begin
                if (w_finish) begin
                    w_state_nxt = halt_in ? ST_HALT : ST_FETCH_HI;
                end else begin
                    w_state_nxt = ST_EXEC_WAIT;
                end
            end
            ST_HALT:       if (!halt_in) w_state_nxt = ST_FETCH_HI;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pc <= c_reset_pc;
            r_hi <= '0;
            r_ir <= '0;
        end else begin
            if ((r_state == ST_FETCH_HI) && w_ack) begin
                r_hi <= mem_rdata_in;
            end
            if ((r_state == ST_FETCH_LO) && w_ack) begin
                r_ir <= c_big_endian ? {r_hi, mem_rdata_in} : {mem_rdata_in, r_hi};
            end
            // PC advances past the instruction before execute; a branch at finish overrides it.
            if (r_state == ST_LOAD_IR) begin
                r_pc <= r_pc + ADDR_W'(2);
            end else if (w_finish && pc_load_in) begin
                r_pc <= pc_load_addr_in & c_even_mask;
            end
        end
    end

    always_comb begin
        mem_req_out  = 1'b0;
        mem_addr_out = '0;
        case (r_state)
            ST_FETCH_HI: begin
                mem_req_out  = 1'b1;
                mem_addr_out = r_pc;
            end
            ST_FETCH_LO: begin
                mem_req_out  = 1'b1;
                mem_addr_out = r_pc + ADDR_W'(1);
            end
            default: begin
                mem_req_out  = 1'b0;
                mem_addr_out = '0;
            end
        endcase
    end

    assign ir_write_en_out = (r_state == ST_LOAD_IR);
    assign exec_start_out  = (r_state == ST_EXEC_START);
    assign halted_out      = (r_state == ST_HALT);
    assign ir_data_out     = r_ir;
    assign pc_out          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer
// Scoreboard bench: stimulus pushes expected fetches, a monitor checks IR loads.
// Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        clk_in     = 1'b0;
    logic        reset_n_in = 1'b1;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in;
    logic [7:0]  mem_rdata_in;
    logic        ir_write_en_out;
    logic [15:0] ir_data_out;
    logic        exec_start_out;
    logic        exec_done_in;
    logic        pc_load_in;
    logic [15:0] pc_load_addr_in;
    logic        halt_in;
    logic        halted_out;
    logic [15:0] pc_out;

    always #5 clk_in = ~clk_in;

    fetch_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0010)
    ) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_rdata_in    (mem_rdata_in),
        .ir_write_en_out (ir_write_en_out),
        .ir_data_out     (ir_data_out),
        .exec_start_out  (exec_start_out),
        .exec_done_in    (exec_done_in),
        .pc_load_in      (pc_load_in),
        .pc_load_addr_in (pc_load_addr_in),
        .halt_in         (halt_in),
        .halted_out      (halted_out),
        .pc_out          (pc_out)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] read_q[$];
    logic [7:0]  mem [0:65535];
    int          tot = 0;
    int          bad = 0;
    int          wait_mode = 0;
    logic [15:0] model_pc;
    logic [15:0] next_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tot++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        make_exp = '{addr: a, word: {mem[a], mem[a1]}};
    endfunction

    // Reference model: the next instruction lives at the (even) next PC.
    task automatic push_next(input logic [15:0] a);
        next_addr = a;
        exp_q.push_back(make_exp(a));
        model_pc = a + 16'd2;
    endtask

    task automatic summary_and_fatal();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $fatal(1, "run aborted");
    endtask

    // Byte-wide memory with 0..2 wait states per read.
    initial begin : memory_responder
        bit          busy;
        int          waits;
        logic [15:0] cur;
        busy = 0;
        waits = 0;
        cur = '0;
        mem_ack_in = 1'b0;
        mem_rdata_in = '0;
        forever begin
            @(negedge clk_in);
            mem_ack_in = 1'b0;
            if (reset_n_in && mem_req_out) begin
                if (!busy) begin
                    busy = 1;
                    cur = mem_addr_out;
                    waits = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
                end else begin
                    chk("addr_stable", mem_addr_out, cur);
                end
                if (waits == 0) begin
                    mem_ack_in = 1'b1;
                    mem_rdata_in = mem[mem_addr_out];
                    busy = 0;
                    read_q.push_back(mem_addr_out);
                end else begin
                    waits--;
                end
            end else begin
                busy = 0;
            end
        end
    end

    initial begin : monitor
        bit          prev_ir;
        logic [15:0] prev_addr;
        logic [15:0] want;
        logic [15:0] got_a;
        exp_t        e;
        prev_ir = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk_in);
            if (!reset_n_in) begin
                prev_ir = 0;
            end else begin
                if (prev_ir) begin
                    chk("exec_start_after_ir", exec_start_out, 1);
                    want = prev_addr + 16'd2;
                    chk("pc_after_load", pc_out, want);
                end else if (exec_start_out) begin
                    tot++;
                    bad++;
                    $display("FAIL stray_exec_start: got 1 expected 0 at %0t", $time);
                end
                prev_ir = 0;
                if (ir_write_en_out) begin
                    chk("no_req_in_load", mem_req_out, 0);
                    if (exp_q.size() == 0) begin
                        tot++;
                        bad++;
                        $display("FAIL unexpected_ir_write: got data %0h expected none", ir_data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ir_data", ir_data_out, e.word);
                        if (read_q.size() < 2) begin
                            tot++;
                            bad++;
                            $display("FAIL read_count: got %0d expected 2", read_q.size());
                        end else begin
                            got_a = read_q.pop_front();
                            chk("hi_addr", got_a, e.addr);
                            got_a = read_q.pop_front();
                            want = e.addr + 16'd1;
                            chk("lo_addr", got_a, want);
                        end
                        prev_ir = 1;
                        prev_addr = e.addr;
                    end
                end
            end
        end
    end

    // Called on the first FETCH_HI negedge; returns on the exec_start negedge.
    task automatic wait_start(input int exp_lat);
        int k;
        k = 1;
        while (!exec_start_out && k < 80) begin
            @(negedge clk_in);
            k++;
        end
        if (!exec_start_out) begin
            tot++;
            bad++;
            $display("FAIL exec_start_timeout: got none expected pulse within 80 cycles");
            summary_and_fatal();
        end
        if (exp_lat > 0) chk("start_latency", k, exp_lat);
    endtask

    // Called on an exec_start negedge; returns on the first negedge of the next fetch.
    task automatic finish_instr(input int d, input bit br, input logic [15:0] tgt,
                                input bit hlt, input int hold, input int nwait);
        for (int i = 0; i < d; i++) begin
            exec_done_in = 1'b0;
            pc_load_in = 1'($urandom);
            pc_load_addr_in = 16'($urandom);
            @(negedge clk_in);
        end
        exec_done_in = 1'b1;
        pc_load_in = br;
        pc_load_addr_in = tgt;
        halt_in = hlt;
        wait_mode = nwait;
        if (br) push_next(tgt & 16'hFFFE);
        else push_next(model_pc);
        @(negedge clk_in);
        exec_done_in = 1'b0;
        pc_load_in = 1'b0;
        pc_load_addr_in = 16'($urandom);
        if (hlt) begin
            for (int i = 0; i < hold; i++) begin
                chk("halted", halted_out, 1);
                chk("halt_no_req", mem_req_out, 0);
                chk("halt_pc", pc_out, next_addr);
                @(negedge clk_in);
            end
            halt_in = 1'b0;
            @(negedge clk_in);
        end
    endtask

    initial begin : stimulus
        int          nw;
        int          k;
        logic [15:0] lo_addr;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'h12;
        mem[16'h0011] = 8'h34;
        exec_done_in = 1'b0;
        pc_load_in = 1'b0;
        pc_load_addr_in = '0;
        halt_in = 1'b0;
        model_pc = '0;
        next_addr = '0;
        #2 reset_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_req", mem_req_out, 0);
        chk("rst_addr", mem_addr_out, 0);
        chk("rst_ir_we", ir_write_en_out, 0);
        chk("rst_exec_start", exec_start_out, 0);
        chk("rst_halted", halted_out, 0);
        chk("rst_ir_data", ir_data_out, 0);
        chk("rst_pc", pc_out, 16'h0010);

        wait_mode = 0;
        push_next(16'h0010);
        reset_n_in = 1'b1;
        @(negedge clk_in);
        wait_start(4);

        finish_instr(0, 1, 16'h0041, 0, 0, 0);  // branch target forced even
        wait_start(4);
        finish_instr(2, 0, 16'h0000, 0, 0, 2);  // two wait states per byte
        wait_start(8);
        finish_instr(1, 1, 16'hFFFF, 0, 0, 0);
        wait_start(4);
        finish_instr(0, 0, 16'h0000, 0, 0, 0);  // fetch at 0xFFFE wraps to 0x0000
        wait_start(4);
        finish_instr(0, 0, 16'h0000, 1, 3, 0);
        wait_start(4);

        for (int n = 0; n < 40; n++) begin
            nw = int'($urandom_range(0, 3));
            if (nw == 3) nw = -1;
            finish_instr(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 16'($urandom),
                         ($urandom_range(0, 7) == 0), int'($urandom_range(1, 3)), nw);
            wait_start((nw < 0) ? 0 : 4 + 2 * nw);
        end

        // Reset while the low-byte ack is pending.
        finish_instr(0, 0, 16'h0000, 0, 0, 1);
        lo_addr = next_addr + 16'd1;
        k = 0;
        #1;
        while (!(mem_ack_in && mem_addr_out == lo_addr) && k < 40) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        chk("lo_ack_reached", (mem_ack_in && mem_addr_out == lo_addr), 1);
        reset_n_in = 1'b0;
        #1;
        chk("async_rst_req", mem_req_out, 0);
        chk("async_rst_addr", mem_addr_out, 0);
        chk("async_rst_ir_we", ir_write_en_out, 0);
        chk("async_rst_exec_start", exec_start_out, 0);
        chk("async_rst_halted", halted_out, 0);
        chk("async_rst_ir_data", ir_data_out, 0);
        chk("async_rst_pc", pc_out, 16'h0010);
        exp_q.delete();
        read_q.delete();
        wait_mode = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_hold_ir_we", ir_write_en_out, 0);
        push_next(16'h0010);
        reset_n_in = 1'b1;
        @(negedge clk_in);
        wait_start(4);
        finish_instr(0, 0, 16'h0000, 0, 0, 0);
        wait_start(4);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
